rf_alu_sequencer: RTL

- Multi-cycle execute and writeback sequencer that sits directly downstream of the register file.
- Accepts a register-to-register ALU command and drives the register file read addresses.
- Consumes Read_Data_0/1, computes the result, and drives the register file write port to commit it.
- Provides the operand-fetch/execute/writeback stage for the single-issue multi-cycle datapath.

---
 rtl/rf_alu_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rf_alu_sequencer.sv
// Execute/writeback sequencer behind the register file: fetches two operands,
// runs one ALU op and commits the result, one command every four cycles.
module rf_alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  Command_Valid,
  output logic                  Command_Ready,
  input  logic [2:0]            Command_Opcode,
  input  logic [ADDR_WIDTH-1:0] Command_Source_0,
  input  logic [ADDR_WIDTH-1:0] Command_Source_1,
  input  logic [ADDR_WIDTH-1:0] Command_Destination,
  output logic [ADDR_WIDTH-1:0] Read_Address_0,
  output logic [ADDR_WIDTH-1:0] Read_Address_1,
  input  logic [DATA_WIDTH-1:0] Read_Data_0,
  input  logic [DATA_WIDTH-1:0] Read_Data_1,
  output logic [ADDR_WIDTH-1:0] Write_Address,
  output logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  Write_Enable,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Zero,
  output logic                  Overflow
);
  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam int MSB  = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL, OP_SRL
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] src0_q, src1_q, dst_q, waddr_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, result_q, wdata_q;
  logic                  zero_q, ovf_q;
  logic [DATA_WIDTH-1:0] alu_d;
  logic                  ovf_d;
  logic                  accept;

  assign accept = (state_q == IDLE) && Command_Valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Command_Valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_d = '0;
    ovf_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_d = a_q + b_q;
        ovf_d = (a_q[MSB] == b_q[MSB]) && (alu_d[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        alu_d = a_q - b_q;
        ovf_d = (a_q[MSB] != b_q[MSB]) && (alu_d[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      OP_XOR:  alu_d = a_q ^ b_q;
      OP_SLT:  alu_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL:  alu_d = a_q << b_q[SH_W-1:0];
      OP_SRL:  alu_d = a_q >> b_q[SH_W-1:0];
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      src0_q   <= '0;
      src1_q   <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_t'(Command_Opcode);
        src0_q <= Command_Source_0;
        src1_q <= Command_Source_1;
        dst_q  <= Command_Destination;
      end
      // Register file read is combinational, so operands are valid by end of READ
      if (state_q == READ) begin
        a_q <= Read_Data_0;
        b_q <= Read_Data_1;
      end
      if (state_q == EXEC) begin
        result_q <= alu_d;
        zero_q   <= (alu_d == '0);
        ovf_q    <= ovf_d;
        waddr_q  <= dst_q;
        wdata_q  <= alu_d;
      end
    end
  end

  assign Command_Ready  = (state_q == IDLE);
  assign Read_Address_0 = src0_q;
  assign Read_Address_1 = src1_q;
  assign Write_Enable   = (state_q == WRITE);
  assign Done           = (state_q == WRITE);
  assign Write_Address  = waddr_q;
  assign Write_Data     = wdata_q;
  assign Result         = result_q;
  assign Zero           = zero_q;
  assign Overflow       = ovf_q;
endmodule
